// File: rtl/lbp_window_engine_if.sv
// Result stream from the LBP window engine to the histogram/classifier stage.
// Signal names keep the engine's port naming so both ends read the same.
interface lbp_window_engine_if;
   logic [7:0] o_code;
   logic [1:0] o_row;
   logic [2:0] o_col;
   logic       o_valid;
   logic       o_last;
   logic       i_ready;

   modport master (
      output o_code, o_row, o_col, o_valid, o_last,
      input  i_ready
   );

   modport slave (
      input  o_code, o_row, o_col, o_valid, o_last,
      output i_ready
   );
endinterface

// File: rtl/lbp_window_engine.sv
// Snapshots a 6x9 pixel window on start and streams the 28 interior 3x3 LBP
// codes in raster order over a valid/ready handshake.
module lbp_window_engine (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [5:0][8:0][7:0]   i_window,
   input  logic                   i_start,
   output logic                   o_busy,
   output logic                   o_done,
   lbp_window_engine_if.master    strm
);

   localparam int unsigned ROWS    = 6;
   localparam int unsigned COLS    = 9;
   localparam int unsigned PIX_W   = 8;
   localparam int unsigned LAST_R  = ROWS - 3;
   localparam int unsigned LAST_C  = COLS - 3;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t                              state_q;
   logic [ROWS-1:0][COLS-1:0][PIX_W-1:0] snap_q;
   logic [1:0]                          pos_r_q;
   logic [2:0]                          pos_c_q;
   logic                                all_loaded_q;
   logic                                busy_q;
   logic                                done_q;
   logic                                valid_q;
   logic                                last_q;
   logic [7:0]                          code_q;
   logic [1:0]                          row_q;
   logic [2:0]                          col_q;

   logic [2:0]                          rn;
   logic [3:0]                          cn;
   logic [7:0][PIX_W-1:0]               nb_c;
   logic [PIX_W-1:0]                    ctr_c;
   logic [7:0]                          code_d;
   logic                                at_end_c;

   assign rn       = {1'b0, pos_r_q};
   assign cn       = {1'b0, pos_c_q};
   assign at_end_c = (pos_r_q == 2'(LAST_R)) && (pos_c_q == 3'(LAST_C));

   // Neighbours clockwise from top-left; each bit is set when neighbour >= centre.
   always_comb begin
      ctr_c   = snap_q[rn + 3'd1][cn + 4'd1];
      nb_c[0] = snap_q[rn][cn];
      nb_c[1] = snap_q[rn][cn + 4'd1];
      nb_c[2] = snap_q[rn][cn + 4'd2];
      nb_c[3] = snap_q[rn + 3'd1][cn + 4'd2];
      nb_c[4] = snap_q[rn + 3'd2][cn + 4'd2];
      nb_c[5] = snap_q[rn + 3'd2][cn + 4'd1];
      nb_c[6] = snap_q[rn + 3'd2][cn];
      nb_c[7] = snap_q[rn + 3'd1][cn];
      code_d  = '0;
      for (int k = 0; k < 8; k++) begin
         code_d[k] = (nb_c[k] >= ctr_c);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         snap_q       <= '0;
         pos_r_q      <= '0;
         pos_c_q      <= '0;
         all_loaded_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         valid_q      <= 1'b0;
         last_q       <= 1'b0;
         code_q       <= '0;
         row_q        <= '0;
         col_q        <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  snap_q       <= i_window;
                  pos_r_q      <= '0;
                  pos_c_q      <= '0;
                  all_loaded_q <= 1'b0;
                  busy_q       <= 1'b1;
                  state_q      <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (all_loaded_q) begin
                  // Output register holds the final code; retire on its handshake.
                  if (valid_q && strm.i_ready) begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end else if (!valid_q || strm.i_ready) begin
                  valid_q      <= 1'b1;
                  code_q       <= code_d;
                  row_q        <= pos_r_q;
                  col_q        <= pos_c_q;
                  last_q       <= at_end_c;
                  all_loaded_q <= at_end_c;
                  if (pos_c_q == 3'(LAST_C)) begin
                     pos_c_q <= '0;
                     pos_r_q <= pos_r_q + 2'd1;
                  end else begin
                     pos_c_q <= pos_c_q + 3'd1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign strm.o_valid = valid_q;
   assign strm.o_last  = last_q;
   assign strm.o_code  = code_q;
   assign strm.o_row   = row_q;
   assign strm.o_col   = col_q;

endmodule

// File: tb/tb_lbp_window_engine.sv
// Randomised self-checking bench for lbp_window_engine against a neighbourhood
// model computed directly from the window pixels.
module tb_lbp_window_engine;

   logic                 clk;
   logic                 rst;
   logic [5:0][8:0][7:0] win;
   logic                 start;
   logic                 busy;
   logic                 done;
   int                   checks;
   int                   failures;
   logic [7:0]           obs_codes [28];

   lbp_window_engine_if strm ();

   lbp_window_engine dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_window (win),
      .i_start  (start),
      .o_busy   (busy),
      .o_done   (done),
      .strm     (strm.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // LBP of the 3x3 neighbourhood whose top-left pixel is (r,c).
   function automatic logic [7:0] ref_code(input logic [5:0][8:0][7:0] w, input int r, input int c);
      int dr [8] = '{0, 0, 0, 1, 2, 2, 2, 1};
      int dc [8] = '{0, 1, 2, 2, 2, 1, 0, 0};
      int ctr;
      logic [7:0] res;
      res = '0;
      ctr = int'(w[r+1][c+1]);
      for (int k = 0; k < 8; k++) begin
         if (int'(w[r+dr[k]][c+dc[k]]) >= ctr) res[k] = 1'b1;
      end
      return res;
   endfunction

   function automatic bit pick_ready(input int mode, input int idx);
      if (mode == 0) return 1'b1;
      if (mode == 1) return ((idx % 4) == 0) || ((idx % 4) == 3);
      return ($urandom % 10) < 7;
   endfunction

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, int'(strm.o_valid), 0);
      check({tag, "_code"},  int'(strm.o_code), 0);
      check({tag, "_row"},   int'(strm.o_row), 0);
      check({tag, "_col"},   int'(strm.o_col), 0);
      check({tag, "_last"},  int'(strm.o_last), 0);
      check({tag, "_done"},  int'(done), 0);
      check({tag, "_busy"},  int'(busy), 0);
   endtask

   // mode: 0 ready always, 1 pattern 1,0,0,1, 2 random. abort_at >= 0 resets after that many handshakes.
   task automatic run_pass(input logic [5:0][8:0][7:0] w, input int mode, input bit iso,
                           input int abort_at, input bit timing);
      logic [7:0] exp_code [28];
      int  n, cyc, first_v, pat, limit;
      bit  rdy, fired;
      for (int i = 0; i < 28; i++) exp_code[i] = ref_code(w, i / 7, i % 7);
      limit = (abort_at >= 0) ? abort_at : 28;
      @(negedge clk);
      win = w;
      start = 1'b1;
      strm.i_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", int'(busy), 1);
      check("valid_after_start", int'(strm.o_valid), 0);
      n = 0; cyc = 0; first_v = -1; pat = 0; fired = 1'b0;
      while (n < limit && cyc < 400) begin
         start = 1'b0;
         if (strm.o_valid) begin
            if (first_v < 0) first_v = cyc;
            check("row", int'(strm.o_row), n / 7);
            check("col", int'(strm.o_col), n % 7);
            check("code", int'(strm.o_code), int'(exp_code[n]));
            check("last", int'(strm.o_last), (n == 27) ? 1 : 0);
            check("done_with_valid", int'(done), 0);
            obs_codes[n] = strm.o_code;
            if (iso && n == 5 && !fired) begin
               win = '0;
               start = 1'b1;
               fired = 1'b1;
            end
         end
         check("busy_in_pass", int'(busy), 1);
         rdy = pick_ready(mode, pat);
         pat++;
         strm.i_ready = rdy;
         if (strm.o_valid && rdy) n++;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (cyc >= 400) check("timeout_handshakes", n, limit);
      if (abort_at >= 0) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         strm.i_ready = 1'b0;
         check_reset_state("midreset");
         @(negedge clk);
         check("midreset_no_done", int'(done), 0);
         check("midreset_idle_valid", int'(strm.o_valid), 0);
         return;
      end
      strm.i_ready = 1'b0;
      check("end_valid", int'(strm.o_valid), 0);
      check("end_done", int'(done), 1);
      check("end_busy", int'(busy), 0);
      check("end_last", int'(strm.o_last), 0);
      if (timing) begin
         check("first_code_latency", first_v, 1);
         check("done_edge", cyc, 29);
      end
      @(negedge clk);
      check("done_pulse_width", int'(done), 0);
      check("idle_valid", int'(strm.o_valid), 0);
   endtask

   initial begin
      logic [5:0][8:0][7:0] w;
      checks = 0;
      failures = 0;
      rst = 1'b1;
      start = 1'b0;
      win = '0;
      strm.i_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_state("reset");

      // Uniform window
      for (int r = 0; r < 6; r++) for (int c = 0; c < 9; c++) w[r][c] = 8'd50;
      run_pass(w, 0, 1'b0, -1, 1'b1);
      for (int i = 0; i < 28; i++) check("uniform_ff", int'(obs_codes[i]), 8'hFF);

      // Column gradient
      for (int r = 0; r < 6; r++) for (int c = 0; c < 9; c++) w[r][c] = 8'(10 * c);
      run_pass(w, 0, 1'b0, -1, 1'b1);
      for (int i = 0; i < 28; i++) check("gradient_3e", int'(obs_codes[i]), 8'h3E);

      // Single dark pixel
      for (int r = 0; r < 6; r++) for (int c = 0; c < 9; c++) w[r][c] = 8'd100;
      w[2][4] = 8'd20;
      run_pass(w, 0, 1'b0, -1, 1'b1);
      check("spot_1_3", int'(obs_codes[10]), 8'hFF);
      check("spot_0_3", int'(obs_codes[3]), 8'hDF);
      check("spot_1_2", int'(obs_codes[9]), 8'hF7);
      check("spot_0_0", int'(obs_codes[0]), 8'hFF);

      // Backpressure 1,0,0,1 on random data
      for (int r = 0; r < 6; r++) for (int c = 0; c < 9; c++) w[r][c] = 8'($urandom);
      run_pass(w, 1, 1'b0, -1, 1'b0);

      // Random data, random ready
      for (int p = 0; p < 3; p++) begin
         for (int r = 0; r < 6; r++) for (int c = 0; c < 9; c++) w[r][c] = 8'($urandom_range(0, 15));
         run_pass(w, 2, 1'b0, -1, 1'b0);
      end

      // Isolation: window cleared and start pulsed mid-pass
      for (int r = 0; r < 6; r++) for (int c = 0; c < 9; c++) w[r][c] = 8'($urandom);
      run_pass(w, 0, 1'b1, -1, 1'b1);

      // Reset after the 10th handshake, then a fresh full pass
      for (int r = 0; r < 6; r++) for (int c = 0; c < 9; c++) w[r][c] = 8'($urandom);
      run_pass(w, 0, 1'b0, 10, 1'b0);
      for (int r = 0; r < 6; r++) for (int c = 0; c < 9; c++) w[r][c] = 8'($urandom);
      run_pass(w, 0, 1'b0, -1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
